// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and
// the default parallel word width.
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    // Encodings 5..7 are unreachable; the controller maps them back to IDLE.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_mux.sv
// Serial line output stage: selects start/data/parity/stop/idle level and
// registers it so TX_OUT never glitches.
module uart_tx_mux
    import uart_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  tx_state_e sel_i,
    input  logic      data_bit_i,
    input  logic      par_bit_i,
    output logic      tx_o
);

    logic tx_d;
    logic tx_q;

    always_comb begin
        tx_d = 1'b1;
        case (sel_i)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_bit_i;
            PARITY:  tx_d = par_bit_i;
            STOP:    tx_d = 1'b1;
            IDLE:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // Line idles high, including while reset is held.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_q <= 1'b1;
        end else begin
            tx_q <= tx_d;
        end
    end

    assign tx_o = tx_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a parallel word as start, LSB-first data,
// optional parity and stop bit, one bit per clock.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
)
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  Par_bit,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  busy_q, busy_d;
    logic                  data_bit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    state_d  = START;
                    data_d   = P_DATA;
                    par_en_d = PAR_EN;
                    cnt_d    = '0;
                end
            end
            START: begin
                // The parity calculator presents its result one cycle after
                // the request, so it is captured here rather than on accept.
                state_d   = DATA;
                cnt_d     = '0;
                par_bit_d = Par_bit;
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Outputs are registered from next-state so the first start bit appears
    // in the cycle right after Data_Valid.
    assign data_bit = data_d[cnt_d];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            busy_q    <= busy_d;
        end
    end

    uart_tx_mux u_mux (
        .clk_i      (CLK),
        .rst_i      (RST),
        .sel_i      (state_d),
        .data_bit_i (data_bit),
        .par_bit_i  (par_bit_d),
        .tx_o       (TX_OUT)
    );

    assign Busy = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed frames plus randomized traffic checked
// against a queue-of-bits line model.
module tb_uart_tx_ctrl;

    localparam int W = 8;

    logic         CLK;
    logic         RST;
    logic [W-1:0] P_DATA;
    logic         Data_Valid;
    logic         PAR_EN;
    logic         Par_bit;
    logic         TX_OUT;
    logic         Busy;

    int n_chk  = 0;
    int n_pass = 0;

    // Expected future line levels; the head is the level shown this cycle.
    bit line[$];
    bit par_pending = 1'b0;
    logic last_tx;
    logic last_busy;

    uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .Par_bit    (Par_bit),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        line.delete();
        par_pending = 1'b0;
    endtask

    // One clock edge of the reference: shift the line, fill in a parity slot
    // once Par_bit is known, and append a new frame when the line was idle.
    task automatic model_step(input bit dv, input logic [W-1:0] d, input bit pen, input bit pb);
        bit was_idle;
        was_idle = (line.size() == 0);
        if (!was_idle) void'(line.pop_front());
        if (par_pending) begin
            line[W] = pb;
            par_pending = 1'b0;
        end
        if (was_idle && dv) begin
            line.push_back(1'b0);
            for (int i = 0; i < W; i++) line.push_back(d[i]);
            if (pen) line.push_back(1'b0);
            line.push_back(1'b1);
            par_pending = pen;
        end
    endtask

    task automatic cycle(input bit dv, input logic [W-1:0] d, input bit pen, input bit pb);
        logic exp_tx;
        Data_Valid = dv;
        P_DATA     = d;
        PAR_EN     = pen;
        Par_bit    = pb;
        @(posedge CLK);
        model_step(dv, d, pen, pb);
        @(negedge CLK);
        exp_tx = (line.size() != 0) ? line[0] : 1'b1;
        chk("tx", 32'(TX_OUT), 32'(exp_tx));
        chk("busy", 32'(Busy), 32'(line.size() != 0));
        last_tx   = TX_OUT;
        last_busy = Busy;
    endtask

    // Request in the first call, then ncyc-1 more; Par_bit held at pb and
    // other inputs scrambled mid-frame. inj_k < 0 disables the stray request.
    task automatic run_frame(input logic [W-1:0] d, input bit pen, input bit pb,
                             input int ncyc, input int inj_k,
                             output logic [15:0] cap, output int bcnt);
        cap  = '0;
        bcnt = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (k == 0)          cycle(1'b1, d, pen, pb);
            else if (k == inj_k) cycle(1'b1, 8'hFF, 1'b1, pb);
            else                 cycle(1'b0, W'($urandom), 1'($urandom), pb);
            cap[k] = last_tx;
            if (last_busy) bcnt++;
        end
    endtask

    logic [15:0] cap;
    int          bcnt;

    initial begin
        RST = 1'b1; Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0; Par_bit = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_tx", 32'(TX_OUT), 32'd1);
        chk("rst_busy", 32'(Busy), 32'd0);
        RST = 1'b0;
        model_reset();

        // Request in the very first cycle after reset release.
        run_frame(8'hA5, 1'b1, 1'b0, 11, -1, cap, bcnt);
        chk("a5_par0_seq", 32'(cap[10:0]), 32'h54A);
        chk("a5_par0_busy", 32'(bcnt), 32'd11);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("a5_par0_idle", 32'(last_tx), 32'd1);

        run_frame(8'hA5, 1'b1, 1'b1, 11, -1, cap, bcnt);
        chk("a5_par1_seq", 32'(cap[10:0]), 32'h74A);
        cycle(1'b0, '0, 1'b0, 1'b0);

        run_frame(8'h0F, 1'b0, 1'b1, 10, -1, cap, bcnt);
        chk("0f_nopar_seq", 32'(cap[9:0]), 32'h21E);
        chk("0f_nopar_busy", 32'(bcnt), 32'd10);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("0f_idle_busy", 32'(last_busy), 32'd0);

        run_frame(8'hA5, 1'b1, 1'b0, 11, 4, cap, bcnt);
        chk("ignore_dv_seq", 32'(cap[10:0]), 32'h54A);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("ignore_dv_idle", 32'(last_busy), 32'd0);

        // Abort a frame with an asynchronous reset mid-cycle n+5.
        run_frame(8'hA5, 1'b1, 1'b0, 5, -1, cap, bcnt);
        RST = 1'b1;
        #1;
        chk("abort_tx", 32'(TX_OUT), 32'd1);
        chk("abort_busy", 32'(Busy), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        chk("abort_hold_tx", 32'(TX_OUT), 32'd1);
        RST = 1'b0;
        model_reset();
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("abort_no_resume", 32'(last_busy), 32'd0);
        run_frame(8'h0F, 1'b0, 1'b0, 10, -1, cap, bcnt);
        chk("after_abort_seq", 32'(cap[9:0]), 32'h21E);

        // Back-to-back: second request in the first idle cycle.
        cycle(1'b0, '0, 1'b0, 1'b0);
        run_frame(8'h3C, 1'b0, 1'b0, 10, -1, cap, bcnt);
        chk("b2b_first", 32'(cap[9:0]), 32'h278);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("b2b_gap_tx", 32'(last_tx), 32'd1);
        chk("b2b_gap_busy", 32'(last_busy), 32'd0);
        run_frame(8'hC3, 1'b0, 1'b0, 10, -1, cap, bcnt);
        chk("b2b_second", 32'(cap[9:0]), 32'h386);
        chk("b2b_second_busy", 32'(bcnt), 32'd10);

        // Randomized traffic: requests and input noise every cycle.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 3) == 0, W'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of the parallel data word.
REQ-002 SHALL have port CLK  input  1  bit clock; one serial bit per CLK cycle; all state on rising edge.
REQ-003 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port P_DATA  input  DATA_WIDTH  parallel data word, valid while Data_Valid high.
REQ-005 SHALL have port Data_Valid  input  1  single-cycle request to transmit P_DATA.
REQ-006 SHALL have port PAR_EN  input  1  parity bit included in frame when high, sampled with Data_Valid.
REQ-007 SHALL have port Par_bit  input  1  parity bit from the parity calculator, registered by that stage on the Data_Valid cycle.
REQ-008 SHALL have port TX_OUT  output  1  serial line, registered, idle high.
REQ-009 SHALL have port Busy  output  1  high while a frame is in progress, registered.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-011 IDLE: TX_OUT=1, Busy=0; Data_Valid=1 -> latch P_DATA and PAR_EN, go START.
REQ-012 START: one cycle, TX_OUT=0; SHALL latch Par_bit in this cycle (first cycle after acceptance); go DATA.
REQ-013 DATA: DATA_WIDTH cycles, TX_OUT = latched bit [cnt], LSB first, cnt 0..DATA_WIDTH-1.
REQ-014 DATA exit at cnt=DATA_WIDTH-1: latched PAR_EN=1 -> PARITY, else -> STOP.
REQ-015 PARITY: one cycle, TX_OUT = latched Par_bit; go STOP.
REQ-016 STOP: one cycle, TX_OUT=1; go IDLE unconditionally.
REQ-017 Latency: Data_Valid in cycle n -> TX_OUT=0 and Busy=1 visible in cycle n+1.
REQ-018 Frame length SHALL be DATA_WIDTH+3 cycles with parity, DATA_WIDTH+2 without; Busy high for exactly the frame.
REQ-019 Data_Valid outside IDLE SHALL be ignored; latched data, PAR_EN and Par_bit SHALL not change mid-frame.
REQ-020 Input changes on P_DATA, PAR_EN or Par_bit after their sampling cycle SHALL not affect the frame.
REQ-021 Minimum gap between frames SHALL be one IDLE cycle (TX_OUT=1).
REQ-022 Bit counter SHALL be $clog2(DATA_WIDTH) bits wide, cleared on START entry, never wrapping in DATA.
REQ-023 Unreachable state encodings SHALL return to IDLE on the next clock.

Reset
REQ-024 RST=1 SHALL force asynchronously: state IDLE, TX_OUT=1, Busy=0, counter 0, data/parity latches 0.
REQ-025 RST during a frame SHALL abort it with no further bits; first frame after release requires a new Data_Valid.
REQ-026 Data_Valid in the first cycle after RST deasserts SHALL be accepted normally.

Structure
REQ-027 Shared package uart_pkg SHALL hold the state enumeration and the DATA_WIDTH default constant.
REQ-028 Output selection SHALL be a sub-module uart_tx_mux (select start/data/parity/stop/idle -> TX_OUT), registered output.
REQ-029 FSM, counter and latches SHALL reside in uart_tx_ctrl; no combinational path from inputs to TX_OUT or Busy.

Verification
REQ-030 P_DATA=0xA5, PAR_EN=1, Par_bit=0 -> TX_OUT from n+1: 0,1,0,1,0,0,1,0,1,0,1; Busy high 11 cycles.
REQ-031 P_DATA=0xA5, PAR_EN=1, Par_bit=1 (odd) -> parity slot (cycle n+10) =1, otherwise identical to REQ-030.
REQ-032 P_DATA=0x0F, PAR_EN=0 -> 0,1,1,1,1,0,0,0,0,1; Busy high 10 cycles; no parity slot.
REQ-033 Data_Valid with P_DATA=0xFF pulsed in cycle n+4 of a 0xA5 frame -> ignored, 0xA5 frame unchanged, returns IDLE.
REQ-034 RST pulsed in cycle n+5 of a frame -> TX_OUT=1, Busy=0 immediately; no STOP bit; next Data_Valid starts clean frame.
REQ-035 Two requests 0x3C then 0xC3 (PAR_EN=0), second asserted first IDLE cycle -> exactly one idle-high cycle between frames, both correct.
